// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor: one SEG-bit segment per stage, valid/ready stream.
// Optional registered signed-overflow output Ovf_Out is enabled by defining CLA_OVF_EN.
module pipelined_cla_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             Clk,
    input  logic             Reset_N,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [WIDTH-1:0] A_In,
    input  logic [WIDTH-1:0] B_In,
    input  logic             C_In,
    input  logic             Sub_In,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [WIDTH-1:0] Sum,
    output logic             C_Out
`ifdef CLA_OVF_EN
    ,
    output logic             Ovf_Out
`endif
);

    localparam int SEG = (STAGES > 0) ? WIDTH / STAGES : WIDTH;

    if ((WIDTH < 2) || (STAGES < 1) || ((WIDTH % ((STAGES > 0) ? STAGES : 1)) != 0)) begin : g_param_check
        $error("pipelined_cla_addsub: need WIDTH >= 2, STAGES >= 1 and WIDTH divisible by STAGES");
    end

    // Returns {carry into segment MSB, segment carry-out, segment sum}.
    function automatic logic [SEG+1:0] seg_add(input logic [SEG-1:0] a,
                                               input logic [SEG-1:0] b,
                                               input logic           cin);
        logic [SEG+1:0] res;
        logic           c;
        logic           g;
        logic           p;
        res = '0;
        c   = cin;
        for (int i = 0; i < SEG; i++) begin
            g          = a[i] & b[i];
            p          = a[i] ^ b[i];
            res[i]     = p ^ c;
            res[SEG+1] = c;
            c          = g | (p & c);
        end
        res[SEG] = c;
        return res;
    endfunction

    logic                          adv_s;
    logic [STAGES-1:0]             valid_r;
    logic [STAGES-1:0]             carry_r;
    logic [STAGES-1:0][WIDTH-1:0]  a_r;
    logic [STAGES-1:0][WIDTH-1:0]  b_r;
    logic [STAGES-1:0][WIDTH-1:0]  sum_r;

    logic [STAGES-1:0]             stg_valid_s;
    logic [STAGES-1:0]             stg_cin_s;
    logic [STAGES-1:0][WIDTH-1:0]  stg_a_s;
    logic [STAGES-1:0][WIDTH-1:0]  stg_b_s;
    logic [STAGES-1:0][WIDTH-1:0]  stg_sum_s;
    logic [STAGES-1:0]             nxt_carry_s;
    logic [STAGES-1:0][WIDTH-1:0]  nxt_a_s;
    logic [STAGES-1:0][WIDTH-1:0]  nxt_b_s;
    logic [STAGES-1:0][WIDTH-1:0]  nxt_sum_s;
    logic                          c_msb_s;

    assign adv_s     = ~valid_r[STAGES-1] | Out_Ready;
    assign In_Ready  = adv_s;
    assign Out_Valid = valid_r[STAGES-1];
    assign Sum       = sum_r[STAGES-1];
    assign C_Out     = carry_r[STAGES-1];

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        logic [SEG+1:0]   seg_res_s;
        logic [WIDTH-1:0] sum_nx_s;
        logic [WIDTH-1:0] a_nx_s;
        logic [WIDTH-1:0] b_nx_s;

        // Mode is resolved here once: later stages only ever see the effective B and carry.
        if (s == 0) begin : g_first
            assign stg_valid_s[0] = In_Valid;
            assign stg_cin_s[0]   = C_In ^ Sub_In;
            assign stg_a_s[0]     = A_In;
            assign stg_b_s[0]     = Sub_In ? ~B_In : B_In;
            assign stg_sum_s[0]   = '0;
        end else begin : g_next
            assign stg_valid_s[s] = valid_r[s-1];
            assign stg_cin_s[s]   = carry_r[s-1];
            assign stg_a_s[s]     = a_r[s-1];
            assign stg_b_s[s]     = b_r[s-1];
            assign stg_sum_s[s]   = sum_r[s-1];
        end

        assign seg_res_s = seg_add(stg_a_s[s][s*SEG +: SEG], stg_b_s[s][s*SEG +: SEG], stg_cin_s[s]);

        // Merge this segment's sum bits and drop operand bits that are now consumed.
        always_comb begin
            sum_nx_s                  = stg_sum_s[s];
            sum_nx_s[s*SEG +: SEG]    = seg_res_s[SEG-1:0];
            a_nx_s                    = stg_a_s[s];
            a_nx_s[(s+1)*SEG-1:0]     = '0;
            b_nx_s                    = stg_b_s[s];
            b_nx_s[(s+1)*SEG-1:0]     = '0;
        end

        assign nxt_sum_s[s]   = sum_nx_s;
        assign nxt_a_s[s]     = a_nx_s;
        assign nxt_b_s[s]     = b_nx_s;
        assign nxt_carry_s[s] = seg_res_s[SEG];

        if (s == STAGES - 1) begin : g_last
            assign c_msb_s = seg_res_s[SEG+1];
        end else begin : g_mid
            logic unused_ctop_s;
            assign unused_ctop_s = seg_res_s[SEG+1];
        end
    end

    logic unused_tail_s;
`ifdef CLA_OVF_EN
    logic ovf_r;
    assign Ovf_Out       = ovf_r;
    assign unused_tail_s = ^{a_r[STAGES-1], b_r[STAGES-1]};
`else
    assign unused_tail_s = ^{a_r[STAGES-1], b_r[STAGES-1], c_msb_s};
`endif

    // Stage registers: every stage shifts forward on advance and holds during a stall.
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            valid_r <= '0;
            carry_r <= '0;
            a_r     <= '0;
            b_r     <= '0;
            sum_r   <= '0;
`ifdef CLA_OVF_EN
            ovf_r   <= 1'b0;
`endif
        end else if (adv_s) begin
            valid_r <= stg_valid_s;
            carry_r <= nxt_carry_s;
            a_r     <= nxt_a_s;
            b_r     <= nxt_b_s;
            sum_r   <= nxt_sum_s;
`ifdef CLA_OVF_EN
            ovf_r   <= nxt_carry_s[STAGES-1] ^ c_msb_s;
`endif
        end
    end

endmodule
